// File: rtl/rtla_capture_sequencer.sv
// Capture sequencer for a ring-buffer logic analyzer: arms a capture,
// waits for completion, then streams the frozen buffer to the host as
// 32-bit words, oldest sample first, least-significant word first.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     host command handshake (cmd_ready always 1)
//   cmd_op                  00 nop, 01 arm, 10 dump, 11 abort
//   la_clear                one-cycle pulse restarting pre-trigger capture
//   la_done                 capture complete, buffer frozen (level)
//   la_start_addr           oldest sample address in the ring
//   la_read_addr            buffer read address
//   la_read_data            buffer data, one cycle after la_read_addr
//   out_valid/out_ready     host stream handshake
//   out_data, out_last      stream word, end-of-dump marker
//   busy, triggered, err    status: not idle, capture held, command rejected

module rtla_capture_sequencer #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    output logic                  la_clear,
    input  logic                  la_done,
    input  logic [ADDR_WIDTH-1:0] la_start_addr,
    output logic [ADDR_WIDTH-1:0] la_read_addr,
    input  logic [DATA_WIDTH-1:0] la_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  triggered,
    output logic                  err
);

    localparam int WORDS = DATA_WIDTH / 32;
    localparam int IW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    localparam logic [IW-1:0]       LAST_IDX    = IW'(WORDS - 1);
    localparam logic [ADDR_WIDTH:0] LAST_SAMPLE = {1'b0, {ADDR_WIDTH{1'b1}}};

    localparam logic [1:0] OP_ARM   = 2'b01;
    localparam logic [1:0] OP_DUMP  = 2'b10;
    localparam logic [1:0] OP_ABORT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_WAIT_TRIG,
        S_READ,
        S_LOAD,
        S_SEND
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0] base;
    // One extra bit so the final sample index never wraps back to zero.
    logic [ADDR_WIDTH:0]   sample_count;
    logic [IW-1:0]         word_idx;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_next;
    logic                  abort_pending;

    logic cmd_fire;
    logic is_arm;
    logic is_dump;
    logic is_abort;
    logic reject;
    logic word_done;
    logic last_word;
    logic final_sample;
    logic abort_hit;

    assign cmd_ready = 1'b1;
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign is_arm    = cmd_fire && (cmd_op == OP_ARM);
    assign is_dump   = cmd_fire && (cmd_op == OP_DUMP);
    assign is_abort  = cmd_fire && (cmd_op == OP_ABORT);

    assign reject = (is_arm && (state != S_IDLE)) ||
                    (is_dump && ((state != S_IDLE) || !triggered));

    assign word_done    = (state == S_SEND) && out_valid && out_ready;
    assign last_word    = (word_idx == LAST_IDX);
    assign final_sample = (sample_count == LAST_SAMPLE);
    assign abort_hit    = is_abort || abort_pending;

    assign shift_next = shift >> 32;

    assign la_read_addr = base + sample_count[ADDR_WIDTH-1:0];
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (is_arm) begin
                    state_next = S_ARM;
                end else if (is_dump && triggered) begin
                    state_next = S_READ;
                end
            end
            S_ARM: begin
                state_next = is_abort ? S_IDLE : S_WAIT_TRIG;
            end
            S_WAIT_TRIG: begin
                if (is_abort || la_done) begin
                    state_next = S_IDLE;
                end
            end
            S_READ: begin
                state_next = is_abort ? S_IDLE : S_LOAD;
            end
            S_LOAD: begin
                state_next = is_abort ? S_IDLE : S_SEND;
            end
            S_SEND: begin
                // An abort never cuts a presented word short; it only
                // takes effect once that word has been accepted.
                if (word_done) begin
                    if (last_word && final_sample) begin
                        state_next = S_IDLE;
                    end else if (abort_hit) begin
                        state_next = S_IDLE;
                    end else if (last_word) begin
                        state_next = S_READ;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            la_clear      <= 1'b0;
            err           <= 1'b0;
            triggered     <= 1'b0;
            base          <= '0;
            sample_count  <= '0;
            word_idx      <= '0;
            shift         <= '0;
            abort_pending <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
        end else begin
            la_clear <= (state == S_IDLE) && is_arm;
            err      <= reject;

            if ((state == S_IDLE) && is_arm) begin
                triggered <= 1'b0;
            end else if ((state == S_WAIT_TRIG) && la_done && !is_abort) begin
                triggered <= 1'b1;
            end

            if ((state == S_IDLE) && is_dump && triggered) begin
                base         <= la_start_addr;
                sample_count <= '0;
            end

            abort_pending <= (state == S_SEND) &&
                             (state_next == S_SEND) &&
                             abort_hit;

            if ((state == S_LOAD) && (state_next == S_SEND)) begin
                shift     <= la_read_data;
                out_data  <= la_read_data[31:0];
                out_valid <= 1'b1;
                word_idx  <= '0;
                out_last  <= (WORDS == 1) && final_sample;
            end

            if (word_done) begin
                if (state_next == S_SEND) begin
                    shift    <= shift_next;
                    out_data <= shift_next[31:0];
                    word_idx <= word_idx + IW'(1);
                    out_last <= ((word_idx + IW'(1)) == LAST_IDX) &&
                                final_sample;
                end else begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
                if (state_next == S_READ) begin
                    sample_count <= sample_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rtla_capture_sequencer.sv
// Directed testbench for rtla_capture_sequencer with a registered
// buffer model whose contents encode address and word position.

module tb_rtla_capture_sequencer;

    localparam int DW = 128;
    localparam int AW = 9;
    localparam int TOTAL_WORDS = 2048;

    localparam logic [1:0] NOP   = 2'b00;
    localparam logic [1:0] ARM   = 2'b01;
    localparam logic [1:0] DUMP  = 2'b10;
    localparam logic [1:0] ABORT = 2'b11;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic          la_clear;
    logic          la_done;
    logic [AW-1:0] la_start_addr;
    logic [AW-1:0] la_read_addr;
    logic [DW-1:0] la_read_data = '0;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_last;
    logic          busy;
    logic          triggered;
    logic          err;

    int vectors = 0;
    int miscompares = 0;

    rtla_capture_sequencer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .la_clear     (la_clear),
        .la_done      (la_done),
        .la_start_addr(la_start_addr),
        .la_read_addr (la_read_addr),
        .la_read_data (la_read_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .triggered    (triggered),
        .err          (err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(input logic [8:0] a,
                                             input int w);
        logic [3:0] wv;
        wv = 4'(w);
        return {wv, 3'b101, a, 7'h2B, a ^ 9'h1FF};
    endfunction

    // Synchronous-read buffer: data follows the address by one cycle.
    always @(posedge clk) begin
        la_read_data <= {exp_word(la_read_addr, 3), exp_word(la_read_addr, 2),
                         exp_word(la_read_addr, 1), exp_word(la_read_addr, 0)};
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = NOP;
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        cmd_valid     = 1'b0;
        cmd_op        = NOP;
        la_done       = 1'b0;
        la_start_addr = '0;
        out_ready     = 1'b0;
        repeat (2) tick();
        vectors++;
        if ({busy, triggered, err, la_clear, out_valid, out_last} !== 6'b0)
            $display("FAIL reset_flags got=%b want=000000",
                     {busy, triggered, err, la_clear, out_valid, out_last});
        if ({busy, triggered, err, la_clear, out_valid, out_last} !== 6'b0)
            miscompares++;
        vectors++;
        if (la_read_addr !== '0 || out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_data addr=%h data=%h want 0/0",
                     la_read_addr, out_data);
        end
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || la_clear !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset valid=%b clear=%b busy=%b want 0/0/0",
                     out_valid, la_clear, busy);
        end
    endtask

    task automatic test_dump_untriggered();
        send_cmd(DUMP);
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL dump_untrig err=%b busy=%b want 1/0", err, busy);
        end
        tick();
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_pulse_width err=%b want 0", err);
        end
        send_cmd(NOP);
        vectors++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL nop err=%b busy=%b want 0/0", err, busy);
        end
        send_cmd(ABORT);
        vectors++;
        if (err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle err=%b busy=%b want 0/0", err, busy);
        end
    endtask

    task automatic test_arm();
        int clears;
        int busy_drops;
        clears = 0;
        busy_drops = 0;
        send_cmd(ARM);
        vectors++;
        if (la_clear !== 1'b1 || busy !== 1'b1 || triggered !== 1'b0) begin
            miscompares++;
            $display("FAIL arm_start clear=%b busy=%b trig=%b want 1/1/0",
                     la_clear, busy, triggered);
        end
        clears += int'(la_clear);
        for (int i = 0; i < 19; i++) begin
            if (i == 5) begin
                send_cmd(ARM);
                vectors++;
                if (err !== 1'b1 || busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL arm_in_wait err=%b busy=%b want 1/1",
                             err, busy);
                end
            end else begin
                tick();
            end
            clears += int'(la_clear);
            if (busy !== 1'b1) busy_drops++;
        end
        vectors++;
        if (busy_drops !== 0) begin
            miscompares++;
            $display("FAIL arm_busy drops=%0d want 0", busy_drops);
        end
        la_done = 1'b1;
        vectors++;
        if (busy !== 1'b1 || triggered !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_before_done busy=%b trig=%b want 1/0",
                     busy, triggered);
        end
        tick();
        la_done = 1'b0;
        vectors++;
        if (busy !== 1'b0 || triggered !== 1'b1) begin
            miscompares++;
            $display("FAIL after_done busy=%b trig=%b want 0/1",
                     busy, triggered);
        end
        vectors++;
        if (clears !== 1) begin
            miscompares++;
            $display("FAIL la_clear_count got=%0d want=1", clears);
        end
    endtask

    task automatic run_dump(input bit bp, input logic [8:0] start);
        int k;
        int gaps;
        int cyc;
        int lasts;
        bit stalled;
        logic [31:0] held;
        logic [31:0] e;
        logic [8:0] a;
        k = 0;
        gaps = 0;
        cyc = 0;
        lasts = 0;
        stalled = 1'b0;
        held = '0;
        la_start_addr = start;
        out_ready = 1'b1;
        send_cmd(DUMP);
        vectors++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL dump_start bp=%0d err=%b busy=%b want 0/1",
                     bp, err, busy);
        end
        while (busy && cyc < 20000) begin
            if (stalled) begin
                vectors++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    miscompares++;
                    $display("FAIL stall_stable word=%0d valid=%b data=%h want 1/%h",
                             k, out_valid, out_data, held);
                end
            end
            if (out_valid) begin
                vectors++;
                if (k < TOTAL_WORDS) begin
                    a = 9'(int'(start) + k / 4);
                    e = exp_word(a, k % 4);
                    if (out_data !== e || out_last !== (k == TOTAL_WORDS - 1)) begin
                        miscompares++;
                        $display("FAIL dump_word bp=%0d k=%0d data=%h last=%b want %h/%b",
                                 bp, k, out_data, out_last, e,
                                 (k == TOTAL_WORDS - 1));
                    end
                end else begin
                    miscompares++;
                    $display("FAIL dump_extra_word bp=%0d k=%0d data=%h",
                             bp, k, out_data);
                end
                if (out_last) lasts++;
            end else begin
                gaps++;
            end
            out_ready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            stalled = out_valid && !out_ready;
            held = out_data;
            if (out_valid && out_ready) k++;
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL dump_timeout bp=%0d busy=%b want 0", bp, busy);
        end
        vectors++;
        if (k !== TOTAL_WORDS || lasts !== 1) begin
            miscompares++;
            $display("FAIL dump_count bp=%0d words=%0d lasts=%0d want %0d/1",
                     bp, k, lasts, TOTAL_WORDS);
        end
        vectors++;
        if (gaps !== 1024) begin
            miscompares++;
            $display("FAIL dump_gaps bp=%0d got=%0d want=1024", bp, gaps);
        end
        vectors++;
        if (triggered !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL dump_end trig=%b valid=%b last=%b want 1/0/0",
                     triggered, out_valid, out_last);
        end
    endtask

    task automatic test_full_dump();
        run_dump(1'b0, 9'h1F0);
    endtask

    task automatic test_backpressure();
        run_dump(1'b1, 9'h1F0);
    endtask

    task automatic test_abort();
        int k;
        int cyc;
        logic [31:0] e;
        k = 0;
        cyc = 0;
        la_start_addr = 9'h1F0;
        out_ready = 1'b1;
        send_cmd(DUMP);
        while (k < 5 && cyc < 100) begin
            if (out_valid) k++;
            tick();
            cyc++;
        end
        e = exp_word(9'h1F1, 1);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== e) begin
            miscompares++;
            $display("FAIL abort_reach_w5 valid=%b data=%h want 1/%h",
                     out_valid, out_data, e);
        end
        out_ready = 1'b0;
        send_cmd(ABORT);
        vectors++;
        if (out_valid !== 1'b1 || out_data !== e || busy !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_held valid=%b data=%h busy=%b err=%b want 1/%h/1/0",
                     out_valid, out_data, busy, err, e);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== e || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_stall2 valid=%b data=%h last=%b want 1/%h/0",
                     out_valid, out_data, out_last, e);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle busy=%b valid=%b last=%b want 0/0/0",
                     busy, out_valid, out_last);
        end
        vectors++;
        if (triggered !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_keeps_trig got=%b want=1", triggered);
        end
        run_dump(1'b0, 9'h1F0);
    endtask

    task automatic test_reset_mid_send();
        int cyc;
        cyc = 0;
        la_start_addr = 9'h0A3;
        out_ready = 1'b0;
        send_cmd(DUMP);
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        vectors++;
        if (out_valid !== 1'b1 || out_data !== exp_word(9'h0A3, 0)) begin
            miscompares++;
            $display("FAIL midsend_first valid=%b data=%h want 1/%h",
                     out_valid, out_data, exp_word(9'h0A3, 0));
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({busy, triggered, err, la_clear, out_valid, out_last} !== 6'b0 ||
            out_data !== '0 || la_read_addr !== '0) begin
            miscompares++;
            $display("FAIL async_reset flags=%b data=%h addr=%h want 0",
                     {busy, triggered, err, la_clear, out_valid, out_last},
                     out_data, la_read_addr);
        end
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || la_clear !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL release valid=%b clear=%b busy=%b want 0/0/0",
                     out_valid, la_clear, busy);
        end
        send_cmd(ARM);
        vectors++;
        if (la_clear !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL rearm clear=%b busy=%b err=%b want 1/1/0",
                     la_clear, busy, err);
        end
        tick();
        la_done = 1'b1;
        tick();
        la_done = 1'b0;
        vectors++;
        if (busy !== 1'b0 || triggered !== 1'b1) begin
            miscompares++;
            $display("FAIL rearm_done busy=%b trig=%b want 0/1",
                     busy, triggered);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_dump_untriggered();
        test_arm();
        test_full_dump();
        test_backpressure();
        test_abort();
        test_reset_mid_send();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
